// File: rtl/dac_spi_target.sv
// ---------------------------------------------------------------------------
// dac_spi_target
//
// SPI target that receives DAC frames from the DAC SPI master and presents
// the resulting DAC output code in the clk domain. It serves as a board
// self-test loopback and as a synthesizable stand-in for the external DAC.
// Every bus input is asynchronous to clk. Inputs are oversampled through
// flip-flop synchronizers and are never used as clocks.
//
// Optional feature macro: DAC_SPI_TARGET_READBACK_EN
//    When defined, the previous input_reg word is shifted out on SDO,
//    MSB first, while the next frame is written (daisy-chain style readback).
//    When undefined, no readback logic is built and SDO is tied to 0.
//
// Parameters
//    DATA_WIDTH  : frame and DAC code width in bits
//    CLR_VALUE   : code loaded by CLRn and by reset
//    SYNC_STAGES : synchronizer depth on every bus input (>= 2)
//
// Ports
//    clk        in  : system clock
//    rst_l      in  : synchronous reset, active high
//    SCK        in  : SPI clock from the master, idle low
//    SDI        in  : serial data from the master, MSB first
//    CSn        in  : frame select, active low
//    LDAc       in  : load DAC, acts on its falling edge
//    CLRn       in  : clear request, active low, level sensitive
//    SDO        out : readback serial data (0 when readback is not built)
//    dac_code   out : currently converted code
//    input_reg  out : last accepted frame
//    frame_ok   out : one-cycle pulse, a frame was accepted
//    frame_err  out : one-cycle pulse, a frame was discarded
//    busy       out : synchronized CSn is low
// ---------------------------------------------------------------------------
module dac_spi_target #(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE   = '0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  SCK,
   input  logic                  SDI,
   input  logic                  CSn,
   input  logic                  LDAc,
   input  logic                  CLRn,
   output logic                  SDO,
   output logic [DATA_WIDTH-1:0] dac_code,
   output logic [DATA_WIDTH-1:0] input_reg,
   output logic                  frame_ok,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int NIN     = 5;
   localparam int IDX_SCK = 0;
   localparam int IDX_SDI = 1;
   localparam int IDX_CS  = 2;
   localparam int IDX_LD  = 3;
   localparam int IDX_CLR = 4;

   // Idle bus levels in {CLRn, LDAc, CSn, SDI, SCK} order.
   localparam logic [NIN-1:0] IDLE_LEVELS = 5'b11100;

   localparam int                CNT_W    = $clog2(DATA_WIDTH + 2);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   logic [NIN-1:0]          sync_q [SYNC_STAGES];
   logic [NIN-1:0]          prev_q;
   logic [SYNC_STAGES:0]    fill_q;
   logic [NIN-1:0]          syncOut;
   logic                    live;

   logic                    sckRise_q;
   logic                    csRise_q;
   logic                    csFall_q;
   logic                    ldFall_q;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        bitCnt_q, bitCnt_d;
   logic [DATA_WIDTH-1:0]   shiftReg_q, shiftReg_d;
   logic [DATA_WIDTH-1:0]   inputReg_q, inputReg_d;
   logic [DATA_WIDTH-1:0]   dacCode_q, dacCode_d;
   logic                    frameOk_q, frameOk_d;
   logic                    frameErr_q, frameErr_d;
   logic                    commit;
   logic                    reject;
   logic                    clrActive;

   assign syncOut = sync_q[SYNC_STAGES-1];

   // The edge-detect register only holds real bus samples once the fill
   // marker has travelled the full synchronizer depth plus one. Until then
   // edges are suppressed, so the reset values in the chain can never fake
   // an edge. This is also what makes a CSn that is already low when reset
   // releases wait for a genuine high-to-low transition.
   assign live = fill_q[SYNC_STAGES];

   // CLRn is taken from the edge-detect register so it is the same age as
   // the edge flags it competes with.
   assign clrActive = ~prev_q[IDX_CLR];

   // Synchronizer chain, edge-detect register and registered edge flags.
   // Registering the edge flags gives an input-to-internal-edge latency of
   // SYNC_STAGES + 1 cycles, so registered outputs follow one cycle later.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= IDLE_LEVELS;
         end
         prev_q    <= IDLE_LEVELS;
         fill_q    <= '0;
         sckRise_q <= 1'b0;
         csRise_q  <= 1'b0;
         csFall_q  <= 1'b0;
         ldFall_q  <= 1'b0;
      end else begin
         sync_q[0] <= {CLRn, LDAc, CSn, SDI, SCK};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q    <= syncOut;
         fill_q    <= {fill_q[SYNC_STAGES-1:0], 1'b1};
         sckRise_q <= live &  syncOut[IDX_SCK] & ~prev_q[IDX_SCK];
         csRise_q  <= live &  syncOut[IDX_CS]  & ~prev_q[IDX_CS];
         csFall_q  <= live & ~syncOut[IDX_CS]  &  prev_q[IDX_CS];
         ldFall_q  <= live & ~syncOut[IDX_LD]  &  prev_q[IDX_LD];
      end
   end

   // Frame state, bit counter, shift register and output registers.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         shiftReg_q <= '0;
         inputReg_q <= CLR_VALUE;
         dacCode_q  <= CLR_VALUE;
         frameOk_q  <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         shiftReg_q <= shiftReg_d;
         inputReg_q <= inputReg_d;
         dacCode_q  <= dacCode_d;
         frameOk_q  <= frameOk_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Next-state logic for the frame receiver. SDI is taken from the
   // edge-detect register because the registered SCK rise flag describes the
   // synchronized sample held there, keeping data and clock aligned.
   // The bit counter saturates one past a full frame so over-length frames
   // can never wrap back to a legal count.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      shiftReg_d = shiftReg_q;
      commit     = 1'b0;
      reject     = 1'b0;
      case (state_q)
         IDLE: begin
            if (csFall_q) begin
               state_d  = SHIFT;
               bitCnt_d = '0;
            end
         end
         SHIFT: begin
            if (csRise_q) begin
               state_d = IDLE;
               if (bitCnt_q == CNT_FULL) begin
                  commit = 1'b1;
               end else begin
                  reject = 1'b1;
               end
            end else if (sckRise_q) begin
               shiftReg_d = {shiftReg_q[DATA_WIDTH-2:0], prev_q[IDX_SDI]};
               if (bitCnt_q != CNT_SAT) begin
                  bitCnt_d = bitCnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Data path priority: CLRn overrides everything, then a frame commit,
   // then an LDAc load. A load in the same cycle as a commit picks up the
   // freshly committed word rather than the stale input register. Frames
   // finishing under CLRn still report ok/err, only their data is dropped.
   always_comb begin
      inputReg_d = inputReg_q;
      dacCode_d  = dacCode_q;
      frameOk_d  = commit;
      frameErr_d = reject;
      if (clrActive) begin
         inputReg_d = CLR_VALUE;
         dacCode_d  = CLR_VALUE;
      end else begin
         if (commit) begin
            inputReg_d = shiftReg_q;
         end
         if (ldFall_q) begin
            dacCode_d = commit ? shiftReg_q : inputReg_q;
         end
      end
   end

`ifdef DAC_SPI_TARGET_READBACK_EN
   logic                  sckFall_q;
   logic [DATA_WIDTH-1:0] readback_q, readback_d;

   // Readback shifter: loaded with the old input register when a frame
   // starts, shifted left on every synchronized SCK fall so the next bit is
   // stable well before the master's following SCK rise.
   always_ff @(posedge clk) begin
      if (rst_l) begin
         sckFall_q  <= 1'b0;
         readback_q <= '0;
      end else begin
         sckFall_q  <= live & ~syncOut[IDX_SCK] & prev_q[IDX_SCK];
         readback_q <= readback_d;
      end
   end

   // Next value of the readback shifter.
   always_comb begin
      readback_d = readback_q;
      if (state_q == IDLE && csFall_q) begin
         readback_d = inputReg_q;
      end else if (state_q == SHIFT && sckFall_q) begin
         readback_d = {readback_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign SDO = (state_q == SHIFT) ? readback_q[DATA_WIDTH-1] : 1'b0;
`else
   assign SDO = 1'b0;
`endif

   assign dac_code  = dacCode_q;
   assign input_reg = inputReg_q;
   assign frame_ok  = frameOk_q;
   assign frame_err = frameErr_q;
   assign busy      = ~syncOut[IDX_CS];

endmodule
